// File: rtl/parser_feature_queue.sv
// parser_feature_queue
// First-word-fall-through record queue between the header parser and the
// inference engine. Holds DEPTH feature records (five-tuple, three-tuple,
// payload window), drives the parser's ready, and counts refused cycles.
// Optional build macro PFQ_FLOW_HASH_EN: tags each record on push with a
// CRC-16/CCITT-FALSE of the five-tuple, presented on out_flow_hash.
// With the macro undefined out_flow_hash is constant zero and no hash is stored.
module parser_feature_queue #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int FIVE_W  = 176,
    parameter int THREE_W = 40,
    parameter int PAY_W   = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FIVE_W-1:0]   in_five_tuple,
    input  logic [THREE_W-1:0]  in_three_tuple,
    input  logic [PAY_W-1:0]    in_payload,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [FIVE_W-1:0]   out_five_tuple,
    output logic [THREE_W-1:0]  out_three_tuple,
    output logic [PAY_W-1:0]    out_payload,
    output logic [15:0]         out_flow_hash,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W:0]     level,
    output logic [31:0]         drop_cnt
);

    localparam int DATA_W = FIVE_W + THREE_W + PAY_W;
`ifdef PFQ_FLOW_HASH_EN
    localparam int REC_W = DATA_W + 16;
`else
    localparam int REC_W = DATA_W;
`endif

    localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    // Slot storage; intentionally not reset, only the pointers define validity.
    logic [REC_W-1:0]  mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [31:0]       drop_cnt_q, drop_cnt_d;

    logic              push;
    logic              pop;
    logic [REC_W-1:0]  wr_rec;
    logic [REC_W-1:0]  rd_rec;

    // Handshake qualifiers are derived purely from registered occupancy.
    assign in_ready  = (level_q != FULL_LVL);
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef PFQ_FLOW_HASH_EN
    // CRC-16/CCITT-FALSE, bit-serial, MSB of the five-tuple first.
    function automatic logic [15:0] crc16_ccitt(input logic [FIVE_W-1:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = FIVE_W - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    assign wr_rec = {crc16_ccitt(in_five_tuple), in_five_tuple, in_three_tuple, in_payload};
`else
    assign wr_rec = {in_five_tuple, in_three_tuple, in_payload};
`endif

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        drop_cnt_d = drop_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push && !pop)      level_d = level_q + LVL_ONE;
        else if (pop && !push) level_d = level_q - LVL_ONE;
        if (in_valid && !in_ready && (drop_cnt_q != 32'hFFFF_FFFF))
            drop_cnt_d = drop_cnt_q + 32'd1;
    end

    // Control state register; reset empties the queue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Record write into the slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_rec;
    end

    // Fall-through head read; data is forced to zero when the queue is empty.
    assign rd_rec = mem_q[rd_ptr_q];

    assign out_payload     = out_valid ? rd_rec[PAY_W-1:0]                : '0;
    assign out_three_tuple = out_valid ? rd_rec[PAY_W +: THREE_W]         : '0;
    assign out_five_tuple  = out_valid ? rd_rec[PAY_W + THREE_W +: FIVE_W] : '0;
`ifdef PFQ_FLOW_HASH_EN
    assign out_flow_hash   = out_valid ? rd_rec[DATA_W +: 16]             : 16'h0000;
`else
    assign out_flow_hash   = 16'h0000;
`endif

    assign level    = level_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_parser_feature_queue.sv
// Self-checking bench for parser_feature_queue: directed scenarios plus
// randomized traffic compared every cycle against a queue-based model.
// Honours PFQ_FLOW_HASH_EN the same way as the design.
module tb_parser_feature_queue;

    localparam int DEPTH = 8;

    typedef struct {
        logic [175:0] f;
        logic [39:0]  t;
        logic [511:0] p;
        logic [15:0]  h;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [175:0]  in_five_tuple = '0;
    logic [39:0]   in_three_tuple = '0;
    logic [511:0]  in_payload = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [175:0]  out_five_tuple;
    logic [39:0]   out_three_tuple;
    logic [511:0]  out_payload;
    logic [15:0]   out_flow_hash;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    level;
    logic [31:0]   drop_cnt;

    parser_feature_queue dut (
        .clk(clk), .rst(rst),
        .in_five_tuple(in_five_tuple), .in_three_tuple(in_three_tuple),
        .in_payload(in_payload), .in_valid(in_valid), .in_ready(in_ready),
        .out_five_tuple(out_five_tuple), .out_three_tuple(out_three_tuple),
        .out_payload(out_payload), .out_flow_hash(out_flow_hash),
        .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    rec_t          mq[$];
    int unsigned   m_drop = 0;
    int            checks = 0;
    int            failures = 0;
    rec_t          zr;

    // Byte-wise CRC-16/CCITT-FALSE over an arbitrary byte string.
    function automatic logic [15:0] crc_bytes(input logic [7:0] b[], input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {b[i], 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] model_hash(input logic [175:0] f);
        logic [7:0] b[];
        b = new[22];
        for (int i = 0; i < 22; i++) b[i] = f[175 - 8*i -: 8];
`ifdef PFQ_FLOW_HASH_EN
        return crc_bytes(b, 22);
`else
        return 16'h0000;
`endif
    endfunction

    function automatic rec_t mk(input logic [31:0] sip, input logic [31:0] dip,
                                input logic [15:0] sp, input logic [15:0] dp,
                                input logic [7:0] pr, input logic [511:0] pay);
        rec_t r;
        r.f = {72'h0, sip, dip, sp, dp, pr};
        r.t = {sp, dp, pr};
        r.p = pay;
        r.h = model_hash(r.f);
        return r;
    endfunction

    function automatic rec_t rnd_rec();
        logic [511:0] pay;
        for (int i = 0; i < 16; i++) pay[32*i +: 32] = $urandom;
        return mk($urandom, $urandom, 16'($urandom), 16'($urandom), 8'($urandom), pay);
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the model state.
    task automatic check_outputs(input string tag);
        rec_t hd;
        hd = (mq.size() != 0) ? mq[0] : zr;
        chk({tag, ":level"},     level,            mq.size());
        chk({tag, ":in_ready"},  in_ready,         mq.size() != DEPTH);
        chk({tag, ":out_valid"}, out_valid,        mq.size() != 0);
        chk({tag, ":drop_cnt"},  drop_cnt,         m_drop);
        chk({tag, ":five"},      out_five_tuple,   hd.f);
        chk({tag, ":three"},     out_three_tuple,  hd.t);
        chk({tag, ":payload"},   out_payload,      hd.p);
        chk({tag, ":hash"},      out_flow_hash,    hd.h);
    endtask

    // One clock cycle: drive, advance the model on the edge, check on negedge.
    task automatic step(input bit v, input rec_t r, input bit ordy, input string tag);
        bit rdy, do_push, do_pop;
        in_valid = v; out_ready = ordy;
        in_five_tuple = r.f; in_three_tuple = r.t; in_payload = r.p;
        rdy     = (mq.size() != DEPTH);
        do_push = v && rdy;
        do_pop  = (mq.size() != 0) && ordy;
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(r);
        if (v && !rdy && m_drop != 32'hFFFF_FFFF) m_drop++;
        @(negedge clk);
        check_outputs(tag);
        $display("cycle %s v=%0d ordy=%0d push=%0d pop=%0d level=%0d drop=%0d",
                 tag, v, ordy, do_push, do_pop, level, drop_cnt);
    endtask

    task automatic idle(input bit ordy, input string tag);
        step(1'b0, zr, ordy, tag);
    endtask

    initial begin
        rec_t r, ra, rb, rx;
        logic [7:0] ref_b[];
        logic [15:0] h1;
        zr.f = '0; zr.t = '0; zr.p = '0; zr.h = '0;

        // Pin the CRC model with the standard check string.
        ref_b = new[9];
        for (int i = 0; i < 9; i++) ref_b[i] = 8'h31 + 8'(i);
        chk("crc_check_123456789", crc_bytes(ref_b, 9), 16'h29B1);

        // Reset state, both during and after reset.
        @(negedge clk);
        check_outputs("reset_hold");
        chk("reset_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("reset_release");

        // Single record.
        r = mk(32'h0A000001, 32'h0, 16'h0, 16'h0050, 8'd6, {64{8'hAB}});
        step(1'b1, r, 1'b0, "single_push");
        chk("single_level", level, 4'd1);
        chk("single_dport", out_three_tuple[23:8], 16'h0050);
        chk("single_sip", out_five_tuple[103:72], 32'h0A000001);
        chk("single_pay", out_payload, {64{8'hAB}});
        idle(1'b1, "single_pop");
        chk("single_empty", level, 4'd0);

        // Fill to full, three refusals, drain in order.
        for (int i = 1; i <= 8; i++)
            step(1'b1, mk(32'h1, 32'h2, 16'(i), 16'h80, 8'd6, 512'(i)), 1'b0, "fill");
        chk("full_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, mk(32'h9, 32'h9, 16'h99, 16'h99, 8'd6, '0), 1'b0, "refuse");
        chk("drop_three", drop_cnt, 32'd3);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_sport", out_three_tuple[39:24], 16'(i));
            idle(1'b1, "drain");
        end

        // Simultaneous push/pop at level 4 for 20 cycles.
        for (int i = 0; i < 4; i++) step(1'b1, rnd_rec(), 1'b0, "prefill4");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, rnd_rec(), 1'b1, "pushpop");
            chk("pushpop_level", level, 4'd4);
        end
        for (int i = 0; i < 4; i++) idle(1'b1, "drain4");

        // Full with pop: pop only, then the retried push is taken.
        for (int i = 0; i < 8; i++) step(1'b1, rnd_rec(), 1'b0, "fill2");
        rx = rnd_rec();
        step(1'b1, rx, 1'b1, "full_pop");
        chk("full_pop_level", level, 4'd7);
        chk("full_pop_drop", drop_cnt, 32'd4);
        step(1'b1, rx, 1'b0, "full_retry");
        chk("full_retry_level", level, 4'd8);

        // Reset mid-stream at level 5 with drop_cnt 2.
        rst = 1'b1; #1; mq.delete(); m_drop = 0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, rnd_rec(), 1'b0, "fill3");
        step(1'b1, rnd_rec(), 1'b0, "refuse3");
        step(1'b1, rnd_rec(), 1'b0, "refuse3");
        for (int i = 0; i < 3; i++) idle(1'b1, "pop3");
        chk("pre_rst_level", level, 4'd5);
        chk("pre_rst_drop", drop_cnt, 32'd2);
        rst = 1'b1; #1;
        mq.delete(); m_drop = 0;
        check_outputs("rst_async");
        @(posedge clk); @(negedge clk);
        check_outputs("rst_hold");
        rst = 1'b0;
        rx = mk(32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, 8'd17, {16{32'hDEADBEEF}});
        step(1'b1, rx, 1'b0, "post_rst");
        chk("post_rst_sport", out_three_tuple[39:24], 16'h1234);
        idle(1'b1, "post_rst_pop");

        // Flow hash behaviour (model yields zero when the tag is disabled).
        ra = mk(32'h0A000001, 32'h0A000002, 16'd1000, 16'd80, 8'd6, '0);
        rb = mk(32'h0A000001, 32'h0A000002, 16'd1000, 16'd80, 8'd17, '0);
        step(1'b1, ra, 1'b0, "hash_a1");
        h1 = out_flow_hash;
        step(1'b1, ra, 1'b0, "hash_a2");
        idle(1'b1, "hash_pop1");
        chk("hash_same_tuple", out_flow_hash, h1);
        idle(1'b1, "hash_pop2");
`ifdef PFQ_FLOW_HASH_EN
        chk("hash_proto_differs", ra.h != rb.h, 1'b1);
`else
        chk("hash_zero_a", ra.h, 16'h0);
`endif
        step(1'b1, rb, 1'b0, "hash_b");
        chk("hash_b_model", out_flow_hash, rb.h);
        idle(1'b1, "hash_pop3");

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, rnd_rec(), $urandom_range(0, 2) != 0, "rand");
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 1) == 0, rnd_rec(), $urandom_range(0, 3) == 0, "rand_bp");
        for (int i = 0; i < 10; i++) idle(1'b1, "final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
